// File: rtl/qkv_proj_pkg.sv
// qkv_proj_pkg: shared types and helpers for the QKV projection engine.
//   proj_state_e : engine FSM state encoding (StIdle, StAccum, StHold).
//   acc_width()  : accumulator width that cannot overflow for an N-term dot product.
//   acc_to_out() : ACCW -> OW conversion. Saturates when PROJ_SAT_EN is defined,
//                  otherwise keeps the low OW bits (two's-complement wrap).
// Config macro: PROJ_SAT_EN
package qkv_proj_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } proj_state_e;

    function automatic int unsigned acc_width(input int unsigned n, input int unsigned dw);
        return 2 * dw + $clog2(n);
    endfunction

    // The result is sign-extended to 64 bits; callers take the low ow bits.
    function automatic logic signed [63:0] acc_to_out(input logic signed [63:0] acc,
                                                      input int unsigned      ow);
`ifdef PROJ_SAT_EN
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (acc > max_v) begin
            return max_v;
        end else if (acc < min_v) begin
            return min_v;
        end
        return acc;
`else
        // Shift the low ow bits to the top and back down to sign-extend them.
        return (acc <<< (64 - ow)) >>> (64 - ow);
`endif
    endfunction

endpackage

// File: rtl/qkv_proj_if.sv
// qkv_proj_if: control, data and handshake bundle of qkv_proj_engine.
//   start/proj_en      : begin a projection, enables {V,K,Q}
//   in_valid/in_ready  : input beat handshake, in_chunk = LANES x DW activations
//   w_q/w_k/w_v        : PE_NUM x LANES x DW weights for the beat at beat_idx
//   out_valid/out_ready: result handshake, out_q/out_k/out_v = PE_NUM x OW results
//   busy               : engine not idle
// Element e of a flat vector lives at [e*W +: W]; weight (pe, lane) is element pe*LANES+lane.
interface qkv_proj_if #(
    parameter int unsigned N      = 768,
    parameter int unsigned DW     = 4,
    parameter int unsigned PE_NUM = 12,
    parameter int unsigned LANES  = 8,
    parameter int unsigned OW     = 2 * DW
);
    localparam int unsigned NB = N / LANES;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

    logic                         start;
    logic [2:0]                   proj_en;
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*DW-1:0]          in_chunk;
    logic [PE_NUM*LANES*DW-1:0]   w_q;
    logic [PE_NUM*LANES*DW-1:0]   w_k;
    logic [PE_NUM*LANES*DW-1:0]   w_v;
    logic [BW-1:0]                beat_idx;
    logic                         out_valid;
    logic                         out_ready;
    logic [PE_NUM*OW-1:0]         out_q;
    logic [PE_NUM*OW-1:0]         out_k;
    logic [PE_NUM*OW-1:0]         out_v;
    logic                         busy;

    modport master (
        output start, proj_en, in_valid, in_chunk, w_q, w_k, w_v, out_ready,
        input  in_ready, beat_idx, out_valid, out_q, out_k, out_v, busy
    );

    modport slave (
        input  start, proj_en, in_valid, in_chunk, w_q, w_k, w_v, out_ready,
        output in_ready, beat_idx, out_valid, out_q, out_k, out_v, busy
    );

endinterface

// File: rtl/qkv_mac_lane.sv
// qkv_mac_lane: one output channel -- LANES-wide signed dot product feeding an accumulator.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clear   : zero the accumulator (start of a projection)
//   i_acc_en  : add this beat's dot product (accepted beat and channel enabled)
//   i_x, i_w  : LANES x DW signed activations / weights
//   o_acc     : accumulator value
module qkv_mac_lane #(
    parameter int unsigned DW    = 4,
    parameter int unsigned LANES = 8,
    parameter int unsigned ACCW  = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_acc_en,
    input  logic [LANES*DW-1:0]    i_x,
    input  logic [LANES*DW-1:0]    i_w,
    output logic signed [ACCW-1:0] o_acc
);

    logic signed [ACCW-1:0] r_acc;
    logic signed [ACCW-1:0] w_dot;

    // Operands are sign-extended to ACCW before multiplying so no product is truncated.
    always_comb begin
        w_dot = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_dot = w_dot + ACCW'($signed(i_x[l*DW +: DW])) * ACCW'($signed(i_w[l*DW +: DW]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_dot;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/qkv_proj_engine.sv
// qkv_proj_engine: Q/K/V projection of an N-element activation vector against PE_NUM
// weight rows per projection, LANES elements per accepted beat.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : qkv_proj_if slave (start/proj_en, input beats, weight fetch, results)
// Results are driven from the accumulators, which hold still in StHold, so outputs are
// stable until out_ready. Disabled projections output 0.
// Config macro: PROJ_SAT_EN (saturate results instead of wrapping).
module qkv_proj_engine
    import qkv_proj_pkg::*;
#(
    parameter int unsigned N      = 768,
    parameter int unsigned DW     = 4,
    parameter int unsigned PE_NUM = 12,
    parameter int unsigned LANES  = 8,
    parameter int unsigned OW     = 2 * DW
) (
    input  logic     clk,
    input  logic     rst,
    qkv_proj_if.slave bus
);

    localparam int unsigned NB   = N / LANES;
    localparam int unsigned BW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned ACCW = acc_width(N, DW);
    localparam int unsigned WV   = LANES * DW;

    proj_state_e   r_state;
    logic [BW-1:0] r_beat;
    logic [2:0]    r_en;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic w_accept;
    logic w_clear;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_clear  = (r_state == StIdle) & bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_beat      <= '0;
            r_en        <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state    <= StAccum;
                        r_beat     <= '0;
                        r_en       <= bus.proj_en;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                StAccum: begin
                    if (bus.in_valid) begin
                        if (r_beat == BW'(NB - 1)) begin
                            r_state     <= StHold;
                            r_beat      <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    logic [PE_NUM*LANES*DW-1:0] w_wt  [3];
    logic [PE_NUM*OW-1:0]       w_out [3];

    assign w_wt[0] = bus.w_q;
    assign w_wt[1] = bus.w_k;
    assign w_wt[2] = bus.w_v;

    for (genvar ch = 0; ch < 3; ch++) begin : g_proj
        for (genvar p = 0; p < int'(PE_NUM); p++) begin : g_pe
            logic signed [ACCW-1:0] w_acc;
            logic signed [63:0]     w_conv;

            qkv_mac_lane #(
                .DW    (DW),
                .LANES (LANES),
                .ACCW  (ACCW)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_clear  (w_clear),
                .i_acc_en (w_accept & r_en[ch]),
                .i_x      (bus.in_chunk),
                .i_w      (w_wt[ch][p*WV +: WV]),
                .o_acc    (w_acc)
            );

            assign w_conv = acc_to_out(64'(w_acc), OW);
            assign w_out[ch][p*OW +: OW] = r_en[ch] ? w_conv[OW-1:0] : '0;
        end
    end

    assign bus.out_q     = w_out[0];
    assign bus.out_k     = w_out[1];
    assign bus.out_v     = w_out[2];
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.beat_idx  = r_beat;

endmodule

// File: tb/tb_qkv_proj_engine.sv
// tb_qkv_proj_engine: randomized and directed checks of qkv_proj_engine against a
// plain-arithmetic projection model (N=8, LANES=4, DW=4, PE_NUM=2, OW=8).
// Config macro: PROJ_SAT_EN (the model follows the same build choice).
module tb_qkv_proj_engine;

    localparam int N  = 8;
    localparam int DW = 4;
    localparam int PE = 2;
    localparam int L  = 4;
    localparam int OW = 8;
    localparam int NB = N / L;

    logic clk;
    logic rst;

    qkv_proj_if #(.N(N), .DW(DW), .PE_NUM(PE), .LANES(L), .OW(OW)) bus ();

    qkv_proj_engine #(.N(N), .DW(DW), .PE_NUM(PE), .LANES(L), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int xs [NB][L];
    int ws [3][NB][PE][L];
    logic [PE*OW-1:0] exp_out [3];
    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int conv(input int acc);
        int r;
`ifdef PROJ_SAT_EN
        r = acc;
        if (r > (1 << (OW - 1)) - 1) r = (1 << (OW - 1)) - 1;
        if (r < -(1 << (OW - 1)))    r = -(1 << (OW - 1));
`else
        r = acc % (1 << OW);
        if (r < 0) r += (1 << OW);
        if (r >= (1 << (OW - 1))) r -= (1 << OW);
`endif
        return r;
    endfunction

    task automatic model(input logic [2:0] en);
        for (int ch = 0; ch < 3; ch++) begin
            for (int p = 0; p < PE; p++) begin
                int acc;
                logic [31:0] vb;
                acc = 0;
                for (int b = 0; b < NB; b++)
                    for (int l = 0; l < L; l++)
                        acc += ws[ch][b][p][l] * xs[b][l];
                vb = en[ch] ? conv(acc) : 0;
                exp_out[ch][p*OW +: OW] = vb[OW-1:0];
            end
        end
    endtask

    task automatic fill_const(input int xv, input int wv);
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < L; l++) begin
                xs[b][l] = xv;
                for (int ch = 0; ch < 3; ch++)
                    for (int p = 0; p < PE; p++) ws[ch][b][p][l] = wv;
            end
    endtask

    task automatic fill_rand();
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < L; l++) begin
                xs[b][l] = int'($urandom_range(0, 15)) - 8;
                for (int ch = 0; ch < 3; ch++)
                    for (int p = 0; p < PE; p++) ws[ch][b][p][l] = int'($urandom_range(0, 15)) - 8;
            end
    endtask

    task automatic drive_beat(input int b);
        logic [31:0] t;
        bus.in_valid = 1'b1;
        for (int l = 0; l < L; l++) begin
            t = xs[b][l];
            bus.in_chunk[l*DW +: DW] = t[DW-1:0];
            for (int p = 0; p < PE; p++) begin
                t = ws[0][b][p][l]; bus.w_q[(p*L+l)*DW +: DW] = t[DW-1:0];
                t = ws[1][b][p][l]; bus.w_k[(p*L+l)*DW +: DW] = t[DW-1:0];
                t = ws[2][b][p][l]; bus.w_v[(p*L+l)*DW +: DW] = t[DW-1:0];
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_q"}, 64'(bus.out_q), 64'(exp_out[0]));
        chk({tag, "_k"}, 64'(bus.out_k), 64'(exp_out[1]));
        chk({tag, "_v"}, 64'(bus.out_v), 64'(exp_out[2]));
    endtask

    // One full projection: gap idle cycles before each beat, out_ready held low for hold cycles.
    task automatic run_op(input logic [2:0] en, input int gap, input int hold);
        model(en);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.proj_en = en;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("busy_accum", 64'(bus.busy), 64'd1);
        chk("in_ready_accum", 64'(bus.in_ready), 64'd1);
        for (int b = 0; b < NB; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.start = (g == 0 && b == 1);
                chk("no_valid_in_gap", 64'(bus.out_valid), 64'd0);
            end
            @(negedge clk);
            bus.start = 1'b0;
            drive_beat(b);
            chk("beat_idx", 64'(bus.beat_idx), 64'(b));
            chk("no_valid_early", 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("in_ready_hold", 64'(bus.in_ready), 64'd0);
        check_outs("result");
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.start     = (h == 0);
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            check_outs("hold_stable");
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("valid_cleared", 64'(bus.out_valid), 64'd0);
        chk("busy_cleared", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.proj_en   = 3'b000;
        bus.in_valid  = 1'b0;
        bus.in_chunk  = '0;
        bus.w_q       = '0;
        bus.w_k       = '0;
        bus.w_v       = '0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #3;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_beat_idx", 64'(bus.beat_idx), 64'd0);
        chk("rst_outs", 64'({bus.out_q, bus.out_k, bus.out_v}), 64'd0);
        @(negedge clk) rst = 1'b0;

        fill_const(1, 1);
        run_op(3'b111, 0, 0);
        fill_const(7, 7);
        run_op(3'b111, 0, 0);
        fill_const(-8, 7);
        run_op(3'b111, 0, 0);

        fill_rand();
        run_op(3'b111, 3, 5);
        fill_rand();
        run_op(3'b010, 1, 0);
        fill_rand();
        run_op(3'b000, 0, 1);

        // Abort after the first beat.
        fill_rand();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.proj_en = 3'b010;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        drive_beat(0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        chk("abort_out_k", 64'(bus.out_k), 64'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        run_op(3'b010, 0, 0);

        for (int t = 0; t < 12; t++) begin
            fill_rand();
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qkv_proj_engine.md
QKV_PROJ_ENGINE -- requirements
Module: qkv_proj_engine

Interface
REQ-001 Parameter N, default 768: hidden size, i.e. the dot-product length.
REQ-002 Parameter DW, default 4: signed input and weight element width.
REQ-003 Parameter PE_NUM, default 12: output channels (heads) per projection.
REQ-004 Parameter LANES, default 8: elements consumed per accepted beat; N SHALL be a multiple of LANES.
REQ-005 Parameter OW, default 2*DW: signed output element width.
REQ-006 clk  input  1  clock; all logic rising-edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  begin one projection; sampled only in IDLE.
REQ-009 proj_en  input  3  enables {V,K,Q}; sampled with start.
REQ-010 in_valid / in_ready  input / output  1 each  input beat handshake.
REQ-011 in_chunk  input  LANES x DW signed  activation elements for the current beat.
REQ-012 w_q, w_k, w_v  input  PE_NUM x LANES x DW signed each  weights for the current beat, indexed by beat_idx.
REQ-013 beat_idx  output  clog2(N/LANES)  beat index for weight fetch; valid combinationally during ACCUM.
REQ-014 out_valid / out_ready  output / input  1 each  result handshake.
REQ-015 out_q, out_k, out_v  output  PE_NUM x OW signed each  projection results.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ACCUM, HOLD.
REQ-018 IDLE->ACCUM on start: clear all accumulators, beat_idx=0, latch proj_en.
REQ-019 in_ready SHALL be 1 only in ACCUM.
REQ-020 Each in_valid&&in_ready beat: every enabled channel adds sum over LANES of (w*x) to its accumulator; beat_idx increments.
REQ-021 Cycles with in_valid=0 in ACCUM SHALL hold all state (stall).
REQ-022 After beat N/LANES-1 is accepted: ACCUM->HOLD; out_valid=1 on the next cycle; total latency = N/LANES accepted beats + 1 cycle.
REQ-023 HOLD: outputs stable while out_valid&&!out_ready; out_valid&&out_ready -> IDLE, out_valid=0.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 Accumulator width ACCW = 2*DW + clog2(N): no internal overflow possible.
REQ-026 Disabled projections SHALL output 0 and their accumulators SHALL not toggle.
REQ-027 proj_en=0 with start: accept N/LANES beats, then output all zeros.

Reset
REQ-028 rst SHALL force: IDLE, accumulators 0, beat_idx 0, out_valid 0, in_ready 0, busy 0, outputs 0.
REQ-029 rst mid-ACCUM or mid-HOLD SHALL abort the operation; no out_valid follows until a new start completes.

Configuration
REQ-030 Macro PROJ_SAT_EN defined: ACCW->OW conversion SHALL saturate to [-2^(OW-1), 2^(OW-1)-1].
REQ-031 Macro PROJ_SAT_EN undefined: the conversion SHALL keep the low OW bits (two's-complement wrap).

Structure
REQ-032 Package qkv_proj_pkg SHALL hold the FSM state enum, the ACCW function, and the saturate/wrap function.
REQ-033 Sub-module qkv_mac_lane SHALL implement one channel (LANES-wide dot product plus accumulator), instantiated 3*PE_NUM times.

Verification (N=8, LANES=4, DW=4, PE_NUM=2, OW=8)
REQ-034 All x=1, all weights=1, proj_en=3'b111 -> after 2 beats, all six outputs =8, out_valid held 1 cycle with out_ready=1.
REQ-035 All x=7, all w=7, PROJ_SAT_EN defined -> acc=392, outputs=127; macro undefined -> outputs=392 mod 256 as signed = -120.
REQ-036 x=-8, w=7 -> acc=-448; with PROJ_SAT_EN outputs=-128.
REQ-037 Gap of 3 idle in_valid cycles between beats -> same result, out_valid delayed 3 cycles; out_ready low for 5 cycles -> outputs stable, start ignored.
REQ-038 proj_en=3'b010 -> only out_k nonzero; rst after beat 1 -> IDLE, no out_valid, next start gives correct result.
